decoder3to8_pulse: RTL and testbench
====================================

Name: decoder3to8_pulse

Overview:
Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a programmable output pulse width. It is the receive-side counterpart of the team's 8:3 encoder. A 3-bit code accepted on the input drives the matching one-hot line of y high for exactly PULSE_CYCLES clocks, then y returns to 8'h00. It sits downstream of the encoder path and drives strobe/select lines that need a guaranteed minimum width.

Parameters:
PULSE_CYCLES, 4, number of clocks each one-hot pulse is held; legal range 1..255; 0 fails an elaboration check.
CNT_W, 8, width of the internal pulse counter; must satisfy 2^CNT_W > PULSE_CYCLES.

Ports:
clk  input  1  single system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  decoder enable; gates acceptance only.
in_valid  input  1  code is valid this cycle.
in_ready  output  1  block can accept a code this cycle.
code  input  3  binary code to decode (0..7, all values legal).
y  output  8  registered one-hot output; 8'h00 when idle.
busy  output  1  high while a pulse is being driven (and during GAP when enabled).
done  output  1  one-cycle strobe marking the end of each pulse.

Behaviour:
- Reset:
  - Reset is asynchronous, active-low on rst_n; all state is on the single clock clk.
  - While rst_n=0: y=8'h00, busy=0, done=0, counter=0, state=IDLE, in_ready=0.
  - in_ready may rise on the first clk edge after rst_n deasserts.
- States: IDLE, DRIVE, plus GAP only when the optional feature is compiled in.
- in_ready = (state==IDLE) && en. This is combinational from state and en.
- Accept condition: in_valid && in_ready sampled at rising edge k.
- On accept at edge k:
  - y <= 8'b1 << code.
  - counter <= PULSE_CYCLES-1.
  - busy <= 1.
  - state <= DRIVE.
  - Result: y is valid from edge k to edge k+PULSE_CYCLES, i.e. exactly PULSE_CYCLES cycles.
- DRIVE with counter != 0: counter decrements by 1; y and code are held. New in_valid is ignored, since in_ready=0.
- DRIVE with counter == 0: at the next edge y <= 8'h00, busy <= 0, done <= 1 for one cycle, state <= IDLE.
- in_ready returns high in the same cycle done is high. Maximum throughput is one pulse per PULSE_CYCLES+1 cycles.
- en:
  - Deasserting en during DRIVE does not truncate the pulse.
  - With en low in IDLE, in_valid is held off and no accept occurs.
- Exactly one bit of y is ever set. y never changes mid-pulse.
- Asserting rst_n low mid-pulse clears y immediately (asynchronously), and no done is produced.
- PULSE_CYCLES=1: y is high for one cycle, and done is asserted the cycle after.

Optional Feature:
Macro DEC_GAP_EN.
- Defined: after DRIVE ends (y=0, done=1), the FSM enters GAP for one cycle.
  - In GAP, in_ready=0 and busy=1; the FSM then returns to IDLE.
  - This guarantees at least 2 low cycles between pulses on y. Period is PULSE_CYCLES+2.
- Undefined: GAP state and its logic are absent; behaviour is exactly as described above.

Decomposition:
- Shared package dec_pkg holds:
  - the state enum typedef (IDLE/DRIVE/GAP);
  - localparam CODE_W=3 and OUT_W=8;
  - a onehot_from_code function.
- One sub-module is natural: pulse_timer, which contains the load/decrement counter and a zero flag. The FSM and output register stay in the top.

Test Plan:
1. Reset, then code=3'd0..3'd7 sent one at a time with en=1, PULSE_CYCLES=4 -> y=8'h01,8'h02,...,8'h80, each high exactly 4 cycles; done pulses once per code; y=8'h00 between pulses.
2. Back-to-back in_valid held high with code=3'd5 -> y=8'h20 for 4 cycles, then 8'h00 with done=1 and in_ready=1 for 1 cycle, then y=8'h20 again. With DEC_GAP_EN, 2 low cycles instead of 1.
3. en=0 with in_valid=1, code=3'd2 -> in_ready=0 and y stays 8'h00. Raising en -> accept; y=8'h04 next edge. Dropping en mid-pulse -> pulse still lasts 4 cycles.
4. rst_n pulled low on the 2nd cycle of a y=8'h10 pulse -> y=8'h00 immediately with no clock; done never asserts; after release, in_ready=1 and the next accept works normally.
5. PULSE_CYCLES=1 build, code=3'd7 -> y=8'h80 for one cycle, done=1 the following cycle, in_ready=1 in that same cycle.
6. code changed while busy (3'd1 -> 3'd6 during DRIVE of 8'h02) -> y holds 8'h02 for its full width; 3'd6 is accepted only when in_ready returns high.

Source files
------------

// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared types, widths and helpers for the 3-to-8 pulse decoder
//
// Purpose : common definitions imported by the decoder interface and top.
// Contents: CODE_W / OUT_W widths, FSM state enum, onehot_from_code helper.

package dec_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  // GAP is always part of the encoding; it is only reachable when the
  // DEC_GAP_EN build option is compiled into the top.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [OUT_W-1:0] onehot_from_code(input logic [CODE_W-1:0] c);
    return OUT_W'(1) << c;
  endfunction

endpackage : dec_pkg

// File: rtl/decoder3to8_pulse_if.sv
// rtl/decoder3to8_pulse_if.sv - code handshake and pulse output bundle for the decoder
//
// Purpose : groups the input handshake (en, in_valid, in_ready, code) and the
//           pulse outputs (y, busy, done) of decoder3to8_pulse.
// Modports: master - upstream source / observer (drives en, in_valid, code)
//           slave  - the decoder (drives in_ready, y, busy, done)

interface decoder3to8_pulse_if;
  import dec_pkg::*;

  logic              en;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] code;
  logic [OUT_W-1:0]  y;
  logic              busy;
  logic              done;

  modport master (
    output en,
    output in_valid,
    output code,
    input  in_ready,
    input  y,
    input  busy,
    input  done
  );

  modport slave (
    input  en,
    input  in_valid,
    input  code,
    output in_ready,
    output y,
    output busy,
    output done
  );

endinterface : decoder3to8_pulse_if

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - loadable down-counter with zero flag that times each pulse
//
// Purpose : holds the remaining-cycles count of the pulse currently driven.
// Ports   : clk      - system clock, rising edge
//           rst_n    - asynchronous active-low reset (count cleared to 0)
//           load     - load load_val this edge (has priority over dec)
//           load_val - value loaded on a new pulse
//           dec      - decrement by one this edge; saturates at zero
//           zero     - count is zero

module pulse_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule : pulse_timer

// File: rtl/decoder3to8_pulse.sv
// rtl/decoder3to8_pulse.sv - registered 3-to-8 one-hot decoder with fixed-width output pulses
//
// Purpose : an accepted 3-bit code drives the matching bit of y for exactly
//           PULSE_CYCLES clocks, then y returns to zero and done strobes once.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - decoder3to8_pulse_if.slave
//                   en       : enable, gates acceptance only
//                   in_valid : code valid
//                   in_ready : (state==IDLE) && en, low during reset
//                   code     : 3-bit code
//                   y        : registered one-hot output, 0 when idle
//                   busy     : pulse in progress (and GAP cycle when built)
//                   done     : one-cycle strobe at end of each pulse
// Build   : DEC_GAP_EN - adds a one-cycle GAP state after each pulse so y
//           stays low for at least two cycles between pulses.

module decoder3to8_pulse
  import dec_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  decoder3to8_pulse_if.slave  bus
);

  if ((PULSE_CYCLES < 1) || (PULSE_CYCLES > 255) || (CNT_W < 1) ||
      ((64'd1 << CNT_W) <= 64'(PULSE_CYCLES))) begin : g_bad_cfg
    $error("decoder3to8_pulse: PULSE_CYCLES must be 1..255 and fit in CNT_W bits");
  end

  state_e           state_q, state_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  // Low until the first clock after reset release, so in_ready is 0 in reset
  // even though the reset state is IDLE.
  logic             alive_q, alive_d;

  logic             in_ready;
  logic             accept;
  logic             cnt_zero;

  assign in_ready = alive_q && (state_q == IDLE) && bus.en;
  assign accept   = bus.in_valid && in_ready;

  pulse_timer #(
    .CNT_W (CNT_W)
  ) u_pulse_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (CNT_W'(PULSE_CYCLES - 1)),
    .dec      (state_q == DRIVE),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    alive_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          y_d     = onehot_from_code(bus.code);
          busy_d  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // The counter was loaded with PULSE_CYCLES-1, so reaching zero here
        // means y has been high for PULSE_CYCLES edges.
        if (cnt_zero) begin
          y_d    = '0;
          done_d = 1'b1;
`ifdef DEC_GAP_EN
          busy_d  = 1'b1;
          state_d = GAP;
`else
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
`ifdef DEC_GAP_EN
      GAP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
`endif
      default: begin
        y_d     = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      alive_q <= alive_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.y        = y_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule : decoder3to8_pulse

// File: tb/tb_decoder3to8_pulse.sv
// tb/tb_decoder3to8_pulse.sv - randomized self-checking bench for decoder3to8_pulse (P=4 and P=1)

module tb_decoder3to8_pulse;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] code = 3'd0;

  always #5 clk = ~clk;

  decoder3to8_pulse_if bus4 ();
  decoder3to8_pulse_if bus1 ();

  assign bus4.en       = en;
  assign bus4.in_valid = in_valid;
  assign bus4.code     = code;
  assign bus1.en       = en;
  assign bus1.in_valid = in_valid;
  assign bus1.code     = code;

  decoder3to8_pulse #(.PULSE_CYCLES(4), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  decoder3to8_pulse #(.PULSE_CYCLES(1), .CNT_W(2)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;

`ifdef DEC_GAP_EN
  int gap = 1;
`else
  int gap = 0;
`endif

  // Timeline model: cycle n is the interval after the n-th clock edge since
  // reset release. A pulse accepted at edge s owns cycles s..s+P-1, done
  // lands on cycle s+P, and the block is free again from s+P (+1 with GAP).
  int         pc [2] = '{4, 1};
  int         s [2];
  logic [2:0] mcode [2];
  bit         have [2];
  bit         acc [2];
  int         n;
  logic [2:0] seq_code;
  int         resets_left;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      int   pend, ready_from;
      bit   in_p, e_done, e_busy, e_ready;
      int   e_y;
      int   g_y, g_busy, g_done, g_ready;
      pend       = have[d] ? s[d] + pc[d] : 0;
      in_p       = have[d] && (n >= s[d]) && (n < pend);
      e_y        = in_p ? (1 << mcode[d]) : 0;
      e_done     = have[d] && (n == pend);
      e_busy     = in_p || ((gap != 0) && e_done);
      ready_from = have[d] ? pend + gap : 1;
      e_ready    = en && (n >= ready_from);
      acc[d]     = in_valid && e_ready;
      if (d == 0) begin
        g_y = int'(bus4.y); g_busy = int'(bus4.busy);
        g_done = int'(bus4.done); g_ready = int'(bus4.in_ready);
      end else begin
        g_y = int'(bus1.y); g_busy = int'(bus1.busy);
        g_done = int'(bus1.done); g_ready = int'(bus1.in_ready);
      end
      check($sformatf("y_p%0d", pc[d]), g_y, e_y);
      check($sformatf("busy_p%0d", pc[d]), g_busy, int'(e_busy));
      check($sformatf("done_p%0d", pc[d]), g_done, int'(e_done));
      check($sformatf("in_ready_p%0d", pc[d]), g_ready, int'(e_ready));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_y_p4"}, int'(bus4.y), 0);
    check({tag, "_busy_p4"}, int'(bus4.busy), 0);
    check({tag, "_done_p4"}, int'(bus4.done), 0);
    check({tag, "_ready_p4"}, int'(bus4.in_ready), 0);
    check({tag, "_y_p1"}, int'(bus1.y), 0);
    check({tag, "_done_p1"}, int'(bus1.done), 0);
    check({tag, "_ready_p1"}, int'(bus1.in_ready), 0);
  endtask

  // mode 1: sequential codes 0..7; 2: valid held with code 5;
  // 3: random en/valid/code; 4: mid-pulse resets; 5: code churn while busy
  task automatic run(input int cycles, input int mode);
    for (int c = 0; c < cycles; c++) begin
      case (mode)
        1: begin en = 1'b1; in_valid = ($urandom_range(0, 2) != 0); code = seq_code; end
        2: begin en = 1'b1; in_valid = 1'b1; code = 3'd5; end
        3: begin en = ($urandom_range(0, 2) != 0); in_valid = $urandom_range(0, 1) == 1;
                 code = 3'($urandom_range(0, 7)); end
        4: begin en = 1'b1; in_valid = 1'b1; code = 3'd4; end
        default: begin en = 1'b1; in_valid = ($urandom_range(0, 9) < 7);
                       code = 3'($urandom_range(0, 7)); end
      endcase
      @(negedge clk);
      check_cycle();
      if (mode == 4 && resets_left > 0 && have[0] && n == s[0] + 1) begin
        resets_left--;
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(posedge clk);
        #1 check_zero("in_rst");
        rst_n = 1'b1;
        n = 0;
        have = '{0, 0};
      end else begin
        @(posedge clk);
        #1;
        n++;
        for (int d = 0; d < 2; d++) begin
          if (acc[d]) begin
            s[d] = n;
            mcode[d] = code;
            have[d] = 1'b1;
            if (d == 0) seq_code = seq_code + 3'd1;
          end
        end
      end
    end
  endtask

  initial begin
    seq_code = 3'd0;
    have = '{0, 0};
    n = 0;
    resets_left = 3;
    rst_n = 1'b0;
    en = 1'b1;
    in_valid = 1'b1;
    code = 3'd3;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;
    n = 0;

    run(90, 1);
    run(30, 2);
    run(120, 3);
    run(60, 4);
    check(" resets_done", resets_left, 0);
    run(200, 5);
    run(150, 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_decoder3to8_pulse
